alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two requesters, the shared ALU units and the arbiter.
// The arbiter takes the slave view; the requester/unit side takes the master view.
interface alu_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             REQ0;
   logic             REQ1;
   logic [3:0]       FUN0;
   logic [3:0]       FUN1;
   logic [WIDTH-1:0] A0;
   logic [WIDTH-1:0] B0;
   logic [WIDTH-1:0] A1;
   logic [WIDTH-1:0] B1;
   logic [WIDTH-1:0] ALU_RES_IN;
   logic             ALU_FLAG_IN;
   logic [WIDTH-1:0] ALU_A;
   logic [WIDTH-1:0] ALU_B;
   logic [1:0]       ALU_FUN;
   logic             Arith_Enable;
   logic             Logic_Enable;
   logic             CMP_Enable;
   logic             SHIFT_Enable;
   logic             GNT0;
   logic             GNT1;
   logic             DONE0;
   logic             DONE1;
   logic [WIDTH-1:0] RES;
   logic             ERR;
   logic             BUSY;

   modport slave (
      input  REQ0, REQ1, FUN0, FUN1, A0, B0, A1, B1, ALU_RES_IN, ALU_FLAG_IN,
      output ALU_A, ALU_B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable,
             SHIFT_Enable, GNT0, GNT1, DONE0, DONE1, RES, ERR, BUSY
   );

   modport master (
      output REQ0, REQ1, FUN0, FUN1, A0, B0, A1, B1, ALU_RES_IN, ALU_FLAG_IN,
      input  ALU_A, ALU_B, ALU_FUN, Arith_Enable, Logic_Enable, CMP_Enable,
             SHIFT_Enable, GNT0, GNT1, DONE0, DONE1, RES, ERR, BUSY
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of four shared ALU units.
// Each operation runs IDLE/RESP -> EXEC -> WAIT -> RESP; every output is registered.
module alu_arbiter #(
   parameter int WIDTH = 16
) (
   input logic         Clk,
   input logic         RST,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic [3:0]       en_q, en_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_fun_q, alu_fun_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;

   logic             any_req;
   logic             win1;
   logic [3:0]       win_fun;

   always_comb begin
      any_req = bus.REQ0 | bus.REQ1;
      // Contention is settled by the pointer; a lone request always wins.
      win1    = (bus.REQ0 & bus.REQ1) ? ptr_q : bus.REQ1;
      win_fun = win1 ? bus.FUN1 : bus.FUN0;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done0_d   = 1'b0;
      done1_d   = 1'b0;
      en_d      = '0;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_fun_d = alu_fun_q;
      res_d     = res_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            if (any_req) begin
               state_d   = ST_EXEC;
               owner_d   = win1;
               ptr_d     = ~win1;
               gnt0_d    = ~win1;
               gnt1_d    = win1;
               alu_a_d   = win1 ? bus.A1 : bus.A0;
               alu_b_d   = win1 ? bus.B1 : bus.B0;
               alu_fun_d = win_fun[1:0];
               en_d      = 4'b0001 << win_fun[3:2];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_RESP;
            res_d   = bus.ALU_RES_IN;
            err_d   = ~bus.ALU_FLAG_IN;
            done0_d = ~owner_q;
            done1_d = owner_q;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 1'b0;
         owner_q   <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         en_q      <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_fun_q <= '0;
         res_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done0_q   <= done0_d;
         done1_q   <= done1_d;
         en_q      <= en_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_fun_q <= alu_fun_d;
         res_q     <= res_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.ALU_A        = alu_a_q;
   assign bus.ALU_B        = alu_b_q;
   assign bus.ALU_FUN      = alu_fun_q;
   assign bus.Arith_Enable = en_q[0];
   assign bus.Logic_Enable = en_q[1];
   assign bus.CMP_Enable   = en_q[2];
   assign bus.SHIFT_Enable = en_q[3];
   assign bus.GNT0         = gnt0_q;
   assign bus.GNT1         = gnt1_q;
   assign bus.DONE0        = done0_q;
   assign bus.DONE1        = done1_q;
   assign bus.RES          = res_q;
   assign bus.ERR          = err_q;
   assign bus.BUSY         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered model of the four ALU units.
module tb_alu_arbiter;

   logic clk;
   logic rst_n;
   logic flag_cfg;
   int   n_checks;
   int   n_fail;

   alu_arbiter_if #(.WIDTH(16)) bus();

   alu_arbiter #(.WIDTH(16)) dut (
      .Clk (clk),
      .RST (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit model: result registered one edge after its enable, zero when idle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.ALU_RES_IN  <= '0;
         bus.ALU_FLAG_IN <= 1'b0;
      end else begin
         logic [15:0] r;
         r = '0;
         if (bus.Arith_Enable) begin
            case (bus.ALU_FUN)
               2'b00: r = bus.ALU_A + bus.ALU_B;
               2'b01: r = bus.ALU_A - bus.ALU_B;
               2'b10: r = bus.ALU_A + 16'd1;
               default: r = bus.ALU_A - 16'd1;
            endcase
         end else if (bus.Logic_Enable) begin
            case (bus.ALU_FUN)
               2'b00: r = bus.ALU_A & bus.ALU_B;
               2'b01: r = bus.ALU_A | bus.ALU_B;
               2'b10: r = bus.ALU_A ^ bus.ALU_B;
               default: r = ~bus.ALU_A;
            endcase
         end else if (bus.CMP_Enable) begin
            case (bus.ALU_FUN)
               2'b00: r = {15'd0, bus.ALU_A == bus.ALU_B};
               2'b01: r = {15'd0, bus.ALU_A > bus.ALU_B};
               2'b10: r = {15'd0, bus.ALU_A < bus.ALU_B};
               default: r = '0;
            endcase
         end else if (bus.SHIFT_Enable) begin
            case (bus.ALU_FUN)
               2'b00: r = bus.ALU_A << bus.ALU_B[3:0];
               2'b01: r = $signed(bus.ALU_A) >>> bus.ALU_B[3:0];
               2'b10: r = {bus.ALU_A[14:0], bus.ALU_A[15]};
               default: r = bus.ALU_A >> bus.ALU_B[3:0];
            endcase
         end
         bus.ALU_RES_IN  <= r;
         bus.ALU_FLAG_IN <= (bus.Arith_Enable | bus.Logic_Enable |
                             bus.CMP_Enable | bus.SHIFT_Enable) ? flag_cfg : 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Leaves RST low at a negedge with all requester inputs cleared.
   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      flag_cfg = 1'b1;
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;
      bus.FUN0 = '0;
      bus.FUN1 = '0;
      bus.A0   = '0;
      bus.B0   = '0;
      bus.A1   = '0;
      bus.B1   = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_gnt"},  {bus.GNT0, bus.GNT1}, 2'b00);
      check_eq({tag, "_done"}, {bus.DONE0, bus.DONE1}, 2'b00);
      check_eq({tag, "_en"},   {bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable, bus.SHIFT_Enable}, 4'b0000);
      check_eq({tag, "_busy"}, bus.BUSY, 1'b0);
      check_eq({tag, "_res"},  bus.RES, 16'h0000);
      check_eq({tag, "_err"},  bus.ERR, 1'b0);
      check_eq({tag, "_alua"}, bus.ALU_A, 16'h0000);
      check_eq({tag, "_alub"}, bus.ALU_B, 16'h0000);
      check_eq({tag, "_fun"},  bus.ALU_FUN, 2'b00);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      flag_cfg = 1'b1;

      // Single logic AND from requester 0
      do_reset();
      check_zero("rst");
      bus.REQ0 = 1'b1;
      bus.FUN0 = 4'b0100;
      bus.A0   = 16'hF0F0;
      bus.B0   = 16'h0FF0;
      rst_n    = 1'b1;
      cyc();
      check_eq("and_c1_gnt0", bus.GNT0, 1'b1);
      check_eq("and_c1_en", {bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable, bus.SHIFT_Enable}, 4'b0100);
      check_eq("and_c1_fun", bus.ALU_FUN, 2'b00);
      check_eq("and_c1_alua", bus.ALU_A, 16'hF0F0);
      check_eq("and_c1_busy", bus.BUSY, 1'b1);
      bus.REQ0 = 1'b0;
      cyc();
      check_eq("and_c2_gnt0", bus.GNT0, 1'b0);
      check_eq("and_c2_en", {bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable, bus.SHIFT_Enable}, 4'b0000);
      check_eq("and_c2_alua_hold", bus.ALU_A, 16'hF0F0);
      check_eq("and_c2_done0", bus.DONE0, 1'b0);
      cyc();
      check_eq("and_c3_done0", bus.DONE0, 1'b1);
      check_eq("and_c3_res", bus.RES, 16'h00F0);
      check_eq("and_c3_err", bus.ERR, 1'b0);
      cyc();
      check_eq("and_c4_done0", bus.DONE0, 1'b0);
      check_eq("and_c4_busy", bus.BUSY, 1'b0);
      check_eq("and_c4_res_hold", bus.RES, 16'h00F0);

      // Round robin, both held: add from 0, shift-right from 1
      do_reset();
      bus.REQ0 = 1'b1;
      bus.FUN0 = 4'b0000;
      bus.A0   = 16'd3;
      bus.B0   = 16'd4;
      bus.REQ1 = 1'b1;
      bus.FUN1 = 4'b1111;
      bus.A1   = 16'h8000;
      bus.B1   = 16'd3;
      rst_n    = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         logic g0, g1, d0, d1;
         cyc();
         g0 = (c == 1) || (c == 7);
         g1 = (c == 4) || (c == 10);
         d0 = (c == 3) || (c == 9);
         d1 = (c == 6) || (c == 12);
         check_eq($sformatf("rr_c%0d_gnt", c), {bus.GNT0, bus.GNT1}, {g0, g1});
         check_eq($sformatf("rr_c%0d_done", c), {bus.DONE0, bus.DONE1}, {d0, d1});
         check_eq($sformatf("rr_c%0d_en", c),
                  {bus.Arith_Enable, bus.Logic_Enable, bus.CMP_Enable, bus.SHIFT_Enable},
                  {g0, 1'b0, 1'b0, g1});
         if (g1) check_eq($sformatf("rr_c%0d_fun", c), bus.ALU_FUN, 2'b11);
         if (d0) check_eq($sformatf("rr_c%0d_res", c), bus.RES, 16'd7);
         if (d1) check_eq($sformatf("rr_c%0d_res", c), bus.RES, 16'h1000);
         check_eq($sformatf("rr_c%0d_busy", c), bus.BUSY, 1'b1);
      end
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;
      cyc();
      check_eq("rr_idle_busy", bus.BUSY, 1'b0);

      // Error flag: compare with flag low, then subtract with flag high
      do_reset();
      flag_cfg = 1'b0;
      bus.REQ0 = 1'b1;
      bus.FUN0 = 4'b1000;
      bus.A0   = 16'd5;
      bus.B0   = 16'd5;
      rst_n    = 1'b1;
      cyc();
      check_eq("err_c1_cmp_en", bus.CMP_Enable, 1'b1);
      bus.REQ0 = 1'b0;
      cyc();
      cyc();
      check_eq("err_c3_done0", bus.DONE0, 1'b1);
      check_eq("err_c3_err", bus.ERR, 1'b1);
      check_eq("err_c3_res", bus.RES, 16'd1);
      flag_cfg = 1'b1;
      bus.REQ0 = 1'b1;
      bus.FUN0 = 4'b0001;
      bus.A0   = 16'd10;
      bus.B0   = 16'd3;
      cyc();
      check_eq("err_c4_gnt0", bus.GNT0, 1'b1);
      bus.REQ0 = 1'b0;
      cyc();
      check_eq("err_c5_err_hold", bus.ERR, 1'b1);
      cyc();
      check_eq("err_c6_done0", bus.DONE0, 1'b1);
      check_eq("err_c6_err", bus.ERR, 1'b0);
      check_eq("err_c6_res", bus.RES, 16'd7);

      // Reset during WAIT with only REQ1 pending
      do_reset();
      bus.REQ1 = 1'b1;
      bus.FUN1 = 4'b0100;
      bus.A1   = 16'hFFFF;
      bus.B1   = 16'h00FF;
      rst_n    = 1'b1;
      cyc();
      check_eq("rstw_c1_gnt1", bus.GNT1, 1'b1);
      cyc();
      rst_n = 1'b0;
      #1;
      check_zero("rstw_async");
      cyc();
      check_eq("rstw_no_done", {bus.DONE0, bus.DONE1}, 2'b00);
      rst_n = 1'b1;
      cyc();
      check_eq("rstw_r1_gnt", {bus.GNT0, bus.GNT1}, 2'b01);
      check_eq("rstw_r1_done", {bus.DONE0, bus.DONE1}, 2'b00);
      bus.REQ1 = 1'b0;
      cyc();
      cyc();
      check_eq("rstw_r3_done1", bus.DONE1, 1'b1);
      check_eq("rstw_r3_res", bus.RES, 16'h00FF);

      // Reset clears the pointer: after granting 0, reset, both pending -> 0 wins
      do_reset();
      bus.REQ0 = 1'b1;
      bus.A0   = 16'd1;
      bus.B0   = 16'd1;
      rst_n    = 1'b1;
      cyc();
      check_eq("ptr_c1_gnt0", bus.GNT0, 1'b1);
      cyc();
      rst_n    = 1'b0;
      bus.REQ1 = 1'b1;
      cyc();
      rst_n = 1'b1;
      cyc();
      check_eq("ptr_r1_gnt", {bus.GNT0, bus.GNT1}, 2'b10);
      bus.REQ0 = 1'b0;
      bus.REQ1 = 1'b0;

      // REQ0 pulsed while busy on a REQ1 op is never served
      do_reset();
      bus.REQ1 = 1'b1;
      bus.FUN1 = 4'b0101;
      bus.A1   = 16'h1200;
      bus.B1   = 16'h0034;
      rst_n    = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (c == 1) bus.REQ1 = 1'b0;
         if (c == 2) bus.REQ0 = 1'b1;
         if (c == 3) bus.REQ0 = 1'b0;
         check_eq($sformatf("pulse_c%0d_gnt0", c), bus.GNT0, 1'b0);
         check_eq($sformatf("pulse_c%0d_done", c), {bus.DONE0, bus.DONE1}, {1'b0, c == 3});
         if (c == 3) check_eq("pulse_c3_res", bus.RES, 16'h1234);
         if (c == 8) check_eq("pulse_c8_busy", bus.BUSY, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
